// File: rtl/redmule_mx_encoder.sv
// rtl/redmule_mx_encoder.sv - FP16 stream to MX block (packed E4M3 + shared E8M0 scale) encoder
//
// Purpose: collects NUM_ELEMS FP16 elements, tracks the block maximum exponent,
//          then emits the packed FP8 (E4M3) block and its shared E8M0 scale on two
//          independently handshaked channels.
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   fp16_valid_i/ready_o/data_i       FP16 element input stream
//   mx_val_valid_o/ready_i/data_o     packed FP8 block output (element i in bits [8*i+7:8*i])
//   mx_exp_valid_o/ready_i/data_o     shared E8M0 scale output
module redmule_mx_encoder #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned BITW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fp16_valid_i,
    output logic              fp16_ready_o,
    input  logic [BITW-1:0]   fp16_data_i,
    output logic              mx_val_valid_o,
    input  logic              mx_val_ready_i,
    output logic [DATA_W-1:0] mx_val_data_o,
    output logic              mx_exp_valid_o,
    input  logic              mx_exp_ready_i,
    output logic [7:0]        mx_exp_data_o
);

    localparam int unsigned NUM_ELEMS = DATA_W / 8;
    localparam int unsigned IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       maxe_q;
    logic             special_q;
    logic             val_taken_q, exp_taken_q;
    // Only sign, exponent and the top three mantissa bits survive truncation to E4M3.
    logic [8:0]       buf_q [NUM_ELEMS];

    logic       accept;
    logic [4:0] in_exp;
    logic       val_hs, exp_hs;
    logic       unused_mant_lsbs;

    assign in_exp           = fp16_data_i[14:10];
    assign accept           = fp16_valid_i && fp16_ready_o;
    assign val_hs           = mx_val_valid_o && mx_val_ready_i;
    assign exp_hs           = mx_exp_valid_o && mx_exp_ready_i;
    assign unused_mant_lsbs = ^fp16_data_i[6:0];

    // E4M3 conversion relative to the block maximum exponent; f is the biased
    // FP8 exponent, kept signed 7-bit so a large exponent gap cannot wrap.
    function automatic logic [7:0] to_e4m3(input logic [8:0] el, input logic [4:0] maxe);
        logic              s;
        logic [4:0]        e;
        logic [2:0]        m;
        logic signed [6:0] f;
        s = el[8];
        e = el[7:3];
        m = el[2:0];
        f = $signed({2'b00, e}) - $signed({2'b00, maxe}) + 7'sd15;
        if (e == 5'd0 || f <= 7'sd0) begin
            return {s, 7'b0};
        end else if (f == 7'sd15 && m == 3'b111) begin
            // S.1111.111 is NaN in E4M3, so the top code saturates to +-448.
            return {s, 4'hF, 3'b110};
        end else begin
            return {s, f[3:0], m};
        end
    endfunction

    always_comb begin
        state_d        = state_q;
        fp16_ready_o   = 1'b0;
        mx_val_valid_o = 1'b0;
        mx_exp_valid_o = 1'b0;
        case (state_q)
            COLLECT: begin
                fp16_ready_o = 1'b1;
                if (fp16_valid_i && idx_q == LAST_IDX) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                mx_val_valid_o = !val_taken_q;
                mx_exp_valid_o = !exp_taken_q;
                if ((val_taken_q || mx_val_ready_i) && (exp_taken_q || mx_exp_ready_i)) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Data outputs depend only on registered state, never on the input stream.
    always_comb begin
        mx_val_data_o = '0;
        mx_exp_data_o = 8'd0;
        if (state_q == EMIT) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                mx_val_data_o[8*i +: 8] = special_q ? 8'h7F : to_e4m3(buf_q[i], maxe_q);
            end
            if (special_q) begin
                mx_exp_data_o = 8'hFF;
            end else if (maxe_q == 5'd0) begin
                mx_exp_data_o = 8'd127;
            end else begin
                // maxe - 15 (FP16 bias) - 8 (E4M3 emax) + 127 (E8M0 bias)
                mx_exp_data_o = {3'b000, maxe_q} + 8'd104;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            maxe_q      <= 5'd0;
            special_q   <= 1'b0;
            val_taken_q <= 1'b0;
            exp_taken_q <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                buf_q[i] <= 9'd0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                buf_q[idx_q] <= {fp16_data_i[15], in_exp, fp16_data_i[9:7]};
                idx_q        <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                // Exponent 31 only raises the flag; zero/subnormal never beats maxe.
                if (in_exp == 5'd31) begin
                    special_q <= 1'b1;
                end else if (in_exp > maxe_q) begin
                    maxe_q <= in_exp;
                end
            end
            if (state_q == EMIT) begin
                if (val_hs) val_taken_q <= 1'b1;
                if (exp_hs) exp_taken_q <= 1'b1;
                if (state_d == COLLECT) begin
                    // Block fully delivered: start the next block from a clean max/flag.
                    val_taken_q <= 1'b0;
                    exp_taken_q <= 1'b0;
                    maxe_q      <= 5'd0;
                    special_q   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_redmule_mx_encoder.sv
// tb/tb_redmule_mx_encoder.sv - directed self-checking bench for redmule_mx_encoder
module tb_redmule_mx_encoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fp16_valid;
    logic         fp16_ready;
    logic [15:0]  fp16_data;
    logic         val_valid;
    logic         val_ready;
    logic [255:0] val_data;
    logic         exp_valid;
    logic         exp_ready;
    logic [7:0]   exp_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] blk  [32];
    logic [7:0]  expb [32];

    always #5 clk = ~clk;

    redmule_mx_encoder dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fp16_valid_i   (fp16_valid),
        .fp16_ready_o   (fp16_ready),
        .fp16_data_i    (fp16_data),
        .mx_val_valid_o (val_valid),
        .mx_val_ready_i (val_ready),
        .mx_val_data_o  (val_data),
        .mx_exp_valid_o (exp_valid),
        .mx_exp_ready_i (exp_ready),
        .mx_exp_data_o  (exp_data)
    );

    task automatic send_block();
        for (int i = 0; i < 32; i++) begin
            fp16_data  = blk[i];
            fp16_valid = 1'b1;
            @(posedge clk); #1;
        end
        fp16_valid = 1'b0;
    endtask

    task automatic drain();
        val_ready = 1'b1;
        exp_ready = 1'b1;
        @(posedge clk); #1;
        val_ready = 1'b0;
        exp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fp16_valid = 1'b0; fp16_data = 16'h0; val_ready = 1'b0; exp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++;
        if (fp16_ready !== 1'b1 || val_valid !== 1'b0 || exp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b val_valid=%b exp_valid=%b, want 1 0 0", fp16_ready, val_valid, exp_valid);
        end
        n_checks++;
        if (val_data !== 256'd0 || exp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: val=%h exp=%h, want zeros", val_data, exp_data);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 32; i++) begin
            fp16_data = 16'h3C00; fp16_valid = 1'b1;
            if (i == 31) begin
                n_checks++;
                if (val_valid !== 1'b0 || exp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ones_early_valid: val=%b exp=%b before last accept, want 0 0", val_valid, exp_valid);
                end
            end
            @(posedge clk); #1;
        end
        fp16_valid = 1'b0;
        n_checks++;
        if (val_valid !== 1'b1 || exp_valid !== 1'b1 || fp16_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_latency: val=%b exp=%b ready=%b, want 1 1 0", val_valid, exp_valid, fp16_ready);
        end
        n_checks++;
        if (exp_data !== 8'd119) begin
            n_fail++;
            $display("FAIL ones_scale: got %0d want 119", exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== 8'h78) begin
                n_fail++;
                $display("FAIL ones_byte%0d: got %h want 78", i, val_data[8*i +: 8]);
            end
        end
        drain();
        n_checks++;
        if (fp16_ready !== 1'b1 || val_valid !== 1'b0 || exp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_return: ready=%b val=%b exp=%b, want 1 0 0", fp16_ready, val_valid, exp_valid);
        end
    endtask

    task automatic test_order();
        for (int i = 0; i < 32; i++) begin blk[i] = 16'h3C00; expb[i] = 8'h70; end
        blk[0] = 16'h4000; expb[0] = 8'h78;
        blk[31] = 16'hBC00; expb[31] = 8'hF0;
        send_block();
        n_checks++;
        if (exp_data !== 8'd120) begin
            n_fail++;
            $display("FAIL order_scale: got %0d want 120", exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== expb[i]) begin
                n_fail++;
                $display("FAIL order_byte%0d: got %h want %h", i, val_data[8*i +: 8], expb[i]);
            end
        end
        drain();
    endtask

    task automatic test_flush_sat();
        for (int i = 0; i < 32; i++) begin blk[i] = 16'h3C00; expb[i] = 8'h00; end
        blk[0] = 16'h7800; expb[0] = 8'h78;
        blk[1] = 16'h3FFF;
        send_block();
        n_checks++;
        if (exp_data !== 8'd134) begin
            n_fail++;
            $display("FAIL flush_scale: got %0d want 134", exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== expb[i]) begin
                n_fail++;
                $display("FAIL flush_byte%0d: got %h want %h", i, val_data[8*i +: 8], expb[i]);
            end
        end
        drain();
        for (int i = 0; i < 32; i++) begin blk[i] = 16'h3C00; expb[i] = 8'h78; end
        blk[0] = 16'h3FFF; expb[0] = 8'h7E;
        blk[9] = 16'hBFFF; expb[9] = 8'hFE;
        send_block();
        n_checks++;
        if (exp_data !== 8'd119) begin
            n_fail++;
            $display("FAIL sat_scale: got %0d want 119", exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== expb[i]) begin
                n_fail++;
                $display("FAIL sat_byte%0d: got %h want %h", i, val_data[8*i +: 8], expb[i]);
            end
        end
        drain();
    endtask

    task automatic test_zero();
        for (int i = 0; i < 32; i++) begin blk[i] = 16'h0000; expb[i] = 8'h00; end
        blk[5] = 16'h8000; expb[5] = 8'h80;
        send_block();
        n_checks++;
        if (exp_data !== 8'd127) begin
            n_fail++;
            $display("FAIL zero_scale: got %0d want 127", exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== expb[i]) begin
                n_fail++;
                $display("FAIL zero_byte%0d: got %h want %h", i, val_data[8*i +: 8], expb[i]);
            end
        end
        drain();
    endtask

    task automatic test_inf();
        for (int i = 0; i < 32; i++) blk[i] = 16'h3C00;
        blk[3] = 16'h7C00;
        send_block();
        n_checks++;
        if (exp_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL inf_scale: got %h want ff", exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== 8'h7F) begin
                n_fail++;
                $display("FAIL inf_byte%0d: got %h want 7f", i, val_data[8*i +: 8]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int val_hs = 0;
        for (int i = 0; i < 32; i++) blk[i] = 16'h3C00;
        send_block();
        val_ready = 1'b1;
        exp_ready = 1'b0;
        // An Inf offered during EMIT must not be absorbed into the next block.
        fp16_data  = 16'h7C00;
        fp16_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (val_valid && val_ready) val_hs++;
            n_checks++;
            if (exp_valid !== 1'b1 || exp_data !== 8'd119 || fp16_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: exp_valid=%b exp=%0d ready=%b, want 1 119 0", c, exp_valid, exp_data, fp16_ready);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (val_hs !== 1) begin
            n_fail++;
            $display("FAIL bp_val_hs: got %0d handshakes want 1", val_hs);
        end
        exp_ready = 1'b1;
        @(posedge clk); #1;
        fp16_valid = 1'b0;
        exp_ready  = 1'b0;
        val_ready  = 1'b0;
        n_checks++;
        if (fp16_ready !== 1'b1 || exp_valid !== 1'b0 || val_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: ready=%b exp=%b val=%b, want 1 0 0", fp16_ready, exp_valid, val_valid);
        end
        for (int i = 0; i < 32; i++) blk[i] = 16'h3C00;
        blk[0] = 16'h4000;
        send_block();
        n_checks++;
        if (exp_data !== 8'd120 || val_data[7:0] !== 8'h78 || val_data[15:8] !== 8'h70) begin
            n_fail++;
            $display("FAIL bp_next: scale=%0d b0=%h b1=%h, want 120 78 70", exp_data, val_data[7:0], val_data[15:8]);
        end
        drain();
    endtask

    task automatic test_reset_midblock();
        for (int i = 0; i < 10; i++) begin
            fp16_data = 16'h7800; fp16_valid = 1'b1;
            @(posedge clk); #1;
        end
        fp16_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (fp16_ready !== 1'b1 || val_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: ready=%b val=%b, want 1 0", fp16_ready, val_valid);
        end
        for (int i = 0; i < 32; i++) begin blk[i] = 16'h3C00; expb[i] = 8'h78; end
        blk[0] = 16'hBC00; expb[0] = 8'hF8;
        send_block();
        n_checks++;
        if (val_valid !== 1'b1 || exp_data !== 8'd119) begin
            n_fail++;
            $display("FAIL rst_mid_scale: valid=%b scale=%0d, want 1 119", val_valid, exp_data);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (val_data[8*i +: 8] !== expb[i]) begin
                n_fail++;
                $display("FAIL rst_mid_byte%0d: got %h want %h", i, val_data[8*i +: 8], expb[i]);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_ones();
        test_order();
        test_flush_sat();
        test_zero();
        test_inf();
        test_backpressure();
        test_reset_midblock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
